// File: rtl/reducer_input_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reducer_input_arbiter_pkg
//  Description : Shared widths, helper functions and FSM state encoding for
//                the reducer input arbiter and its record FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package reducer_input_arbiter_pkg;

    localparam int c_DEFAULT_KEY_WIDTH   = 32;
    localparam int c_DEFAULT_VALUE_WIDTH = 32;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width with a floor of one bit, used for dest and pointer fields
    function automatic int idx_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    typedef enum logic [0:0] {
        ST_ARB = 1'b0,
        ST_ACK = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mr_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mr_sync_fifo
//  Description : Show-ahead synchronous FIFO. Head data is visible on o_data
//                whenever o_empty is low; a pop advances to the next entry.
//                Pushes while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mr_sync_fifo
    import reducer_input_arbiter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage array; contents need no reset since o_empty qualifies the head
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read/write pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/reducer_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reducer_input_arbiter
//  Description : Reducer front end. Filters partitioner offers addressed to
//                this reducer, grants one round-robin every other cycle,
//                buffers the record in a show-ahead FIFO and returns a
//                one-cycle ack to the winner. Counts accepted records.
//  Revision    : 1.0 - initial release
// ============================================================================
module reducer_input_arbiter
    import reducer_input_arbiter_pkg::*;
#(
    parameter int NUM_OF_PARTITIONERS = 3,
    parameter int NUM_OF_REDUCERS     = 2,
    parameter int REDUCER_ID          = 0,
    parameter int KEY_WIDTH           = c_DEFAULT_KEY_WIDTH,
    parameter int VALUE_WIDTH         = c_DEFAULT_VALUE_WIDTH,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                                                     clock,
    input  logic                                                     reset,
    input  logic [NUM_OF_PARTITIONERS-1:0]                           i_valid,
    input  logic [NUM_OF_PARTITIONERS*idx_width(NUM_OF_REDUCERS)-1:0] i_dest,
    input  logic [NUM_OF_PARTITIONERS*KEY_WIDTH-1:0]                 i_key,
    input  logic [NUM_OF_PARTITIONERS*VALUE_WIDTH-1:0]               i_value,
    output logic [NUM_OF_PARTITIONERS-1:0]                           o_ack,
    output logic                                                     o_valid,
    output logic [KEY_WIDTH-1:0]                                     o_key,
    output logic [VALUE_WIDTH-1:0]                                   o_value,
    input  logic                                                     i_ready,
    output logic                                                     o_full,
    output logic [15:0]                                              o_accepted
);

    localparam int c_N  = NUM_OF_PARTITIONERS;
    localparam int c_DW = idx_width(NUM_OF_REDUCERS);
    localparam int c_PW = idx_width(NUM_OF_PARTITIONERS);
    localparam int c_RW = KEY_WIDTH + VALUE_WIDTH;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [c_N-1:0]         r_ack;
    logic [c_PW-1:0]        r_ptr;
    logic [15:0]            r_accepted;

    logic [c_N-1:0]         w_req;
    logic                   w_found;
    logic [c_PW-1:0]        w_winner;
    logic                   w_grant;
    logic [KEY_WIDTH-1:0]   w_key_sel;
    logic [VALUE_WIDTH-1:0] w_val_sel;
    logic [c_RW-1:0]        w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;

    // A partitioner requests only when its destination names this reducer
    generate
        for (genvar p = 0; p < c_N; p++) begin : g_req
            assign w_req[p] = i_valid[p] &&
                              (i_dest[p*c_DW +: c_DW] == c_DW'(REDUCER_ID));
        end
    endgenerate

    // Round-robin search: first request at or after ptr+1, wrapping
    always_comb begin
        int v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int i = 1; i <= c_N; i++) begin
            v_idx = (int'(r_ptr) + i) % c_N;
            if (!w_found && w_req[c_PW'(v_idx)]) begin
                w_found  = 1'b1;
                w_winner = c_PW'(v_idx);
            end
        end
    end

    // Record mux selecting the winner's key/value slice
    always_comb begin
        w_key_sel = '0;
        w_val_sel = '0;
        for (int p = 0; p < c_N; p++) begin
            if (w_winner == c_PW'(p)) begin
                w_key_sel = i_key[p*KEY_WIDTH +: KEY_WIDTH];
                w_val_sel = i_value[p*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end
    end

    // Next-state logic; a full FIFO blocks the grant even if a pop coincides
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_found && !w_full) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_ARB;
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack pulse, round-robin pointer and saturating accept counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ack      <= '0;
            r_ptr      <= c_PW'(c_N - 1);
            r_accepted <= '0;
        end else begin
            r_ack <= w_grant ? (c_N'(1) << w_winner) : '0;
            if (w_grant) begin
                r_ptr <= w_winner;
                if (r_accepted != 16'hFFFF) begin
                    r_accepted <= r_accepted + 16'd1;
                end
            end
        end
    end

    assign w_pop = i_ready && !w_empty;

    mr_sync_fifo #(
        .WIDTH (c_RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_grant),
        .i_data  ({w_key_sel, w_val_sel}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_ack      = r_ack;
    assign o_valid    = !w_empty;
    assign o_key      = w_head[c_RW-1 -: KEY_WIDTH];
    assign o_value    = w_head[VALUE_WIDTH-1:0];
    assign o_full     = w_full;
    assign o_accepted = r_accepted;

endmodule
`default_nettype wire

// File: tb/tb_reducer_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reducer_input_arbiter
//  Description : Directed self-checking bench for reducer_input_arbiter.
//                Two instances (reducer 0 and reducer 1) share one set of
//                partitioner inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reducer_input_arbiter;

    localparam int c_N  = 3;
    localparam int c_KW = 32;
    localparam int c_VW = 32;

    logic              clk;
    logic              rst;
    logic [c_N-1:0]    i_valid;
    logic [c_N-1:0]    i_dest;
    logic [c_N*c_KW-1:0] i_key;
    logic [c_N*c_VW-1:0] i_value;
    logic              i_ready;

    logic [c_N-1:0]    o_ack0, o_ack1;
    logic              o_valid0, o_valid1;
    logic [c_KW-1:0]   o_key0, o_key1;
    logic [c_VW-1:0]   o_value0, o_value1;
    logic              o_full0, o_full1;
    logic [15:0]       o_acc0, o_acc1;

    int n_vec;
    int n_err;

    reducer_input_arbiter #(
        .NUM_OF_PARTITIONERS (c_N), .NUM_OF_REDUCERS (2), .REDUCER_ID (0),
        .KEY_WIDTH (c_KW), .VALUE_WIDTH (c_VW), .FIFO_DEPTH (4)
    ) dut0 (
        .clock (clk), .reset (rst), .i_valid (i_valid), .i_dest (i_dest),
        .i_key (i_key), .i_value (i_value), .o_ack (o_ack0),
        .o_valid (o_valid0), .o_key (o_key0), .o_value (o_value0),
        .i_ready (i_ready), .o_full (o_full0), .o_accepted (o_acc0)
    );

    reducer_input_arbiter #(
        .NUM_OF_PARTITIONERS (c_N), .NUM_OF_REDUCERS (2), .REDUCER_ID (1),
        .KEY_WIDTH (c_KW), .VALUE_WIDTH (c_VW), .FIFO_DEPTH (4)
    ) dut1 (
        .clock (clk), .reset (rst), .i_valid (i_valid), .i_dest (i_dest),
        .i_key (i_key), .i_value (i_value), .o_ack (o_ack1),
        .o_valid (o_valid1), .o_key (o_key1), .o_value (o_value1),
        .i_ready (i_ready), .o_full (o_full1), .o_accepted (o_acc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_part(input int p, input logic v, input logic d, input logic [31:0] k);
        i_valid[p]            = v;
        i_dest[p]             = d;
        i_key[p*c_KW +: c_KW] = k;
        i_value[p*c_VW +: c_VW] = ~k;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
        i_dest  = '0;
        i_key   = '0;
        i_value = '0;
        i_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0]  exp_ack [8];
        logic [31:0] exp_key [8];
        int          acks;
        logic [31:0] key;

        n_vec = 0;
        n_err = 0;

        // ---- 1. reset in the middle of an ACK cycle ----
        do_reset();
        check("rst_ack", 32'(o_ack0), 32'h0);
        check("rst_valid", 32'(o_valid0), 32'h0);
        check("rst_full", 32'(o_full0), 32'h0);
        check("rst_acc", 32'(o_acc0), 32'h0);
        set_part(1, 1'b1, 1'b0, 32'h1111_0001);
        tick();
        check("t1_ack_before_rst", 32'(o_ack0), 32'h2);
        check("t1_valid_before_rst", 32'(o_valid0), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_ack_async_rst", 32'(o_ack0), 32'h0);
        check("t1_valid_async_rst", 32'(o_valid0), 32'h0);
        check("t1_acc_async_rst", 32'(o_acc0), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        check("t1_regrant_ack", 32'(o_ack0), 32'h2);
        check("t1_regrant_acc", 32'(o_acc0), 32'h1);
        check("t1_regrant_key", o_key0, 32'h1111_0001);
        check("t1_regrant_value", o_value0, ~32'h1111_0001);

        // ---- 2. round-robin fairness, one ack every two cycles ----
        do_reset();
        set_part(0, 1'b1, 1'b0, 32'h2000_0000);
        set_part(1, 1'b1, 1'b0, 32'h2000_0001);
        set_part(2, 1'b1, 1'b0, 32'h2000_0002);
        i_ready = 1'b1;
        exp_ack = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        exp_key = '{32'h2000_0000, 32'h0, 32'h2000_0001, 32'h0,
                    32'h2000_0002, 32'h0, 32'h2000_0000, 32'h0};
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t2_ack_%0d", i), 32'(o_ack0), 32'(exp_ack[i]));
            if (exp_ack[i] != 3'b000) begin
                check($sformatf("t2_key_%0d", i), o_key0, exp_key[i]);
            end
        end
        check("t2_acc", 32'(o_acc0), 32'h4);

        // ---- 3. destination filtering on reducer 1 ----
        do_reset();
        set_part(0, 1'b1, 1'b0, 32'h3000_0000);
        set_part(2, 1'b1, 1'b1, 32'h3000_0002);
        tick();
        check("t3_ack_0", 32'(o_ack1), 32'h4);
        check("t3_head_key", o_key1, 32'h3000_0002);
        tick();
        check("t3_ack_1", 32'(o_ack1), 32'h0);
        tick();
        check("t3_ack_2", 32'(o_ack1), 32'h4);
        tick();
        check("t3_ack_3", 32'(o_ack1), 32'h0);
        check("t3_acc", 32'(o_acc1), 32'h2);

        // ---- 4. FIFO full blocks grants; one pop frees one slot ----
        do_reset();
        key = 32'h4000_0000;
        set_part(0, 1'b1, 1'b0, key);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_ack0[0]) begin
                acks++;
                key = key + 32'd1;
                set_part(0, 1'b1, 1'b0, key);
            end
        end
        check("t4_acks_to_full", 32'(acks), 32'd4);
        check("t4_full", 32'(o_full0), 32'h1);
        check("t4_acc", 32'(o_acc0), 32'h4);
        check("t4_head", o_key0, 32'h4000_0000);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("t4_no_grant_on_pop", 32'(o_ack0), 32'h0);
        check("t4_head_after_pop", o_key0, 32'h4000_0001);
        check("t4_not_full", 32'(o_full0), 32'h0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_ack0[0]) acks++;
        end
        check("t4_one_more_ack", 32'(acks), 32'd1);
        check("t4_full_again", 32'(o_full0), 32'h1);

        // ---- 5. simultaneous push and pop keeps count ----
        do_reset();
        set_part(1, 1'b1, 1'b0, 32'h5000_0000);
        tick();
        set_part(1, 1'b1, 1'b0, 32'h5000_0001);
        tick();
        tick();
        set_part(1, 1'b1, 1'b0, 32'h5000_0002);
        tick();
        check("t5_head0", o_key0, 32'h5000_0000);
        i_ready = 1'b1;
        tick();
        set_part(1, 1'b0, 1'b0, 32'h0);
        check("t5_ack", 32'(o_ack0), 32'h2);
        check("t5_head1", o_key0, 32'h5000_0001);
        tick();
        check("t5_valid2", 32'(o_valid0), 32'h1);
        check("t5_head2", o_key0, 32'h5000_0002);
        tick();
        check("t5_empty", 32'(o_valid0), 32'h0);
        check("t5_acc", 32'(o_acc0), 32'h3);

        // ---- 6. accept counter saturation ----
        do_reset();
        dut0.r_accepted = 16'hFFFE;
        set_part(0, 1'b1, 1'b0, 32'h6000_0000);
        i_ready = 1'b1;
        tick();
        check("t6_acc_first", 32'(o_acc0), 32'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        check("t6_acc_sat", 32'(o_acc0), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
